decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage, placed between fetch and execute. It replaces the purely combinational decode path.
- Decodes a 32-bit instruction into control fields and a sign-extended immediate, then holds them in an ID/EX output register with a valid/ready handshake.
- Detects load-use hazards against the instruction currently in its output register and inserts one bubble per hazard.
- Supports a synchronous flush and an optional M-extension decode.

Parameters:
- XLEN, 32, width of PC and immediate paths; legal values are 32 and 64; immediates are sign-extended to XLEN.
- EN_M_EXT, 0, when 1, decodes OP with f7=0000001 as MUL/DIV class; when 0, that encoding is illegal.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  kill the held instruction and the offered instruction (taken branch/jump)
- out_valid  out  1  output register holds a valid decoded instruction
- out_ready  in  1  execute consumes the output this cycle
- out_pc  out  XLEN  registered PC
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate; 0 for R-type
- out_func3  out  3  instr[14:12]
- out_alu_code  out  5  {mext, f7b5, func3}; ADD=00000, SUB=01000
- out_wreg, out_wmem, out_rmem, out_is_load  out  1 each  writeback/memory controls
- out_alu_pc, out_alu_imm  out  1 each  ALU operand A=PC, operand B=imm
- out_is_branch, out_is_jump  out  1 each  BRANCH; JAL/JALR
- out_illegal  out  1  unsupported opcode or encoding
- bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0, async): out_valid=0, every out_* field=0, bubble_count=0. in_ready takes the combinational value with out_valid=0, i.e. 1 unless flush is high.
- Decode is combinational from in_instr and is captured on the acceptance edge. Latency is exactly 1 cycle from acceptance to out_valid.
- Opcode decode:
  - OPIMM: alu_code = {0, f7b5, func3} when func3=101; {0, 1, 011} when func3=011; {0, 0, func3} otherwise.
  - OP: {mext, f7b5, func3}.
  - LUI, AUIPC, LOAD, STORE, JAL, JALR: ADD. BRANCH: SUB.
  - Control flags match the existing per-opcode signal sets. JALR sets alu_imm=1 and alu_pc=0.
- Illegal encodings: unknown opcode, OP with f7 not in {0000000, 0100000, 0000001 when EN_M_EXT}, or shift-immediate with a bad f7. These set out_illegal=1 and force wreg, wmem and rmem to 0. An illegal instruction still flows through the stage.
- Register-use rules:
  - Uses rs1: all opcodes except LUI, AUIPC and JAL.
  - Uses rs2: OP, STORE, BRANCH.
- hazard = out_valid & out_is_load & (out_rd != 0) & in_valid & ((uses_rs1 & rs1 == out_rd) | (uses_rs2 & rs2 == out_rd)).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Per-cycle priority, highest first:
  1. flush: out_valid <= 0; the offered instruction is dropped (in_ready=0); bubble_count is unchanged.
  2. hazard & out_ready: the load advances; out_valid <= 0 (bubble); bubble_count += 1, saturating at all-ones. The dependent instruction stays offered and is accepted on the next cycle.
  3. hazard & !out_ready: hold all state.
  4. in_valid & in_ready: capture the decoded fields; out_valid <= 1.
  5. out_ready & !accept: out_valid <= 0.
  6. Otherwise: hold.
- While out_valid=1 & out_ready=0, every out_* field is held stable.
- Back-to-back acceptance every cycle is possible when there is no hazard.
- Data fields are don't-care while out_valid=0, but the implementation zeroes them on flush.
- A reset asserted mid-transfer clears state immediately. The first acceptance after reset release is possible on the first clk edge with rst_n=1.
- Saturation: bubble_count stays at 2^CNT_W-1 once reached.

Test Plan:
1. Reset, then offer ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next cycle: out_valid=1, out_rd=1, out_rs1=0, out_imm=5, out_alu_code=00000, out_wreg=1, out_alu_imm=1.
2. LW x2,0(x1) followed by ADD x3,x2,x2, out_ready=1 throughout -> exactly one cycle with out_valid=0 between them, bubble_count=1, ADD appears 2 cycles after LW. Repeat with rd=x0 -> no bubble.
3. SRAI x4,x4,3 (0x40325213) -> out_alu_code=01101, out_imm=3. BEQ offset -4 -> out_imm=0xFFFFFFFC, out_alu_code=01000, out_is_branch=1.
4. out_ready held low for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. Release -> one transfer per cycle with no loss or duplication.
5. Assert flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, offered instruction not captured, bubble_count unchanged. With EN_M_EXT=0, MUL (0x02208033) -> out_illegal=1, out_wreg=0. With EN_M_EXT=1 -> out_illegal=0, out_alu_code=10000.
6. CNT_W=2: force 5 load-use bubbles -> bubble_count=3. Assert rst_n low mid-stream -> out_valid=0 and bubble_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with load-use bubble insertion
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit EN_M_EXT = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_func3,
    output logic [4:0]       out_alu_code,
    output logic             out_wreg,
    output logic             out_wmem,
    output logic             out_rmem,
    output logic             out_is_load,
    output logic             out_alu_pc,
    output logic             out_alu_imm,
    output logic             out_is_branch,
    output logic             out_is_jump,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b01000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      func3;
        logic [4:0]      alu_code;
        logic            wreg;
        logic            wmem;
        logic            rmem;
        logic            is_load;
        logic            alu_pc;
        logic            alu_imm;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } dec_t;

    logic [6:0]   w_opcode;
    logic [2:0]   w_func3;
    logic [6:0]   w_f7;
    logic [6:0]   w_sh_top;
    logic [31:0]  w_shamt;
    logic [31:0]  w_imm32;
    logic         w_known;
    logic         w_bad_f7;
    logic         w_uses_rs1;
    logic         w_uses_rs2;
    logic         w_hazard;
    logic         w_accept;
    dec_t         w_dec;
    dec_t         r_dec;
    logic         r_valid;
    logic [CNT_W-1:0] r_bubbles;

    assign w_opcode = in_instr[6:0];
    assign w_func3  = in_instr[14:12];
    assign w_f7     = in_instr[31:25];

    // RV64 shift-immediates carry a 6-bit shamt, so the funct field check moves up one bit
    always_comb begin
        w_shamt  = '0;
        w_sh_top = '0;
        if (XLEN == 64) begin
            w_shamt  = {26'b0, in_instr[25:20]};
            w_sh_top = {in_instr[31:26], 1'b0};
        end else begin
            w_shamt  = {27'b0, in_instr[24:20]};
            w_sh_top = in_instr[31:25];
        end
    end

    always_comb begin
        w_dec      = '0;
        w_imm32    = '0;
        w_known    = 1'b1;
        w_bad_f7   = 1'b0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        w_dec.pc    = in_pc;
        w_dec.rs1   = in_instr[19:15];
        w_dec.rs2   = in_instr[24:20];
        w_dec.rd    = in_instr[11:7];
        w_dec.func3 = w_func3;
        w_dec.alu_code = ALU_ADD;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.wreg    = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32       = {in_instr[31:12], 12'b0};
                w_uses_rs1    = 1'b0;
            end
            OPC_AUIPC: begin
                w_dec.wreg    = 1'b1;
                w_dec.alu_pc  = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32       = {in_instr[31:12], 12'b0};
                w_uses_rs1    = 1'b0;
            end
            OPC_JAL: begin
                w_dec.wreg    = 1'b1;
                w_dec.is_jump = 1'b1;
                w_dec.alu_pc  = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
                w_uses_rs1    = 1'b0;
            end
            OPC_JALR: begin
                w_dec.wreg    = 1'b1;
                w_dec.is_jump = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_BRANCH: begin
                w_dec.is_branch = 1'b1;
                w_dec.alu_code  = ALU_SUB;
                w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
                w_uses_rs2      = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.wreg    = 1'b1;
                w_dec.rmem    = 1'b1;
                w_dec.is_load = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                w_dec.wmem    = 1'b1;
                w_dec.alu_imm = 1'b1;
                w_imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_uses_rs2    = 1'b1;
            end
            OPC_OPIMM: begin
                w_dec.wreg    = 1'b1;
                w_dec.alu_imm = 1'b1;
                if (w_func3 == 3'b001 || w_func3 == 3'b101) begin
                    w_imm32  = w_shamt;
                    w_bad_f7 = !((w_sh_top == 7'b0000000) ||
                                 (w_func3 == 3'b101 && w_sh_top == 7'b0100000));
                end else begin
                    w_imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                if (w_func3 == 3'b101)
                    w_dec.alu_code = {1'b0, in_instr[30], w_func3};
                else if (w_func3 == 3'b011)
                    w_dec.alu_code = {1'b0, 1'b1, 3'b011};
                else
                    w_dec.alu_code = {1'b0, 1'b0, w_func3};
            end
            OPC_OP: begin
                w_dec.wreg     = 1'b1;
                w_uses_rs2     = 1'b1;
                w_dec.alu_code = {(w_f7 == 7'b0000001), in_instr[30], w_func3};
                w_bad_f7 = !((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000) ||
                             (EN_M_EXT && w_f7 == 7'b0000001));
            end
            default: w_known = 1'b0;
        endcase
        w_dec.imm     = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
        w_dec.illegal = !w_known || w_bad_f7;
        // an illegal instruction still travels to execute, but must not touch state
        if (w_dec.illegal) begin
            w_dec.wreg = 1'b0;
            w_dec.wmem = 1'b0;
            w_dec.rmem = 1'b0;
        end
    end

    assign w_hazard = r_valid && r_dec.is_load && (r_dec.rd != 5'd0) && in_valid &&
                      ((w_uses_rs1 && (w_dec.rs1 == r_dec.rd)) ||
                       (w_uses_rs2 && (w_dec.rs2 == r_dec.rd)));
    assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_dec     <= '0;
            r_bubbles <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (w_hazard) begin
            if (out_ready) begin
                r_valid <= 1'b0;
                if (r_bubbles != {CNT_W{1'b1}})
                    r_bubbles <= r_bubbles + CNT_W'(1);
            end
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_dec.pc;
    assign out_rs1       = r_dec.rs1;
    assign out_rs2       = r_dec.rs2;
    assign out_rd        = r_dec.rd;
    assign out_imm       = r_dec.imm;
    assign out_func3     = r_dec.func3;
    assign out_alu_code  = r_dec.alu_code;
    assign out_wreg      = r_dec.wreg;
    assign out_wmem      = r_dec.wmem;
    assign out_rmem      = r_dec.rmem;
    assign out_is_load   = r_dec.is_load;
    assign out_alu_pc    = r_dec.alu_pc;
    assign out_alu_imm   = r_dec.alu_imm;
    assign out_is_branch = r_dec.is_branch;
    assign out_is_jump   = r_dec.is_jump;
    assign out_illegal   = r_dec.illegal;
    assign bubble_count  = r_bubbles;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage (RV32, with and without M)
module tb_decode_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid, flush, out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            a_in_ready, a_out_valid;
    logic [XLEN-1:0] a_pc, a_imm;
    logic [4:0]      a_rs1, a_rs2, a_rd, a_alu;
    logic [2:0]      a_f3;
    logic            a_wreg, a_wmem, a_rmem, a_load, a_apc, a_aimm, a_br, a_jmp, a_ill;
    logic [1:0]      a_bub;

    logic            b_in_ready, b_out_valid;
    logic [XLEN-1:0] b_pc, b_imm;
    logic [4:0]      b_rs1, b_rs2, b_rd, b_alu;
    logic [2:0]      b_f3;
    logic            b_wreg, b_wmem, b_rmem, b_load, b_apc, b_aimm, b_br, b_jmp, b_ill;
    logic [15:0]     b_bub;

    decode_stage #(.XLEN(XLEN), .EN_M_EXT(1'b0), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_func3(a_f3), .out_alu_code(a_alu), .out_wreg(a_wreg), .out_wmem(a_wmem),
        .out_rmem(a_rmem), .out_is_load(a_load), .out_alu_pc(a_apc), .out_alu_imm(a_aimm),
        .out_is_branch(a_br), .out_is_jump(a_jmp), .out_illegal(a_ill), .bubble_count(a_bub)
    );

    decode_stage #(.XLEN(XLEN), .EN_M_EXT(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_func3(b_f3), .out_alu_code(b_alu), .out_wreg(b_wreg), .out_wmem(b_wmem),
        .out_rmem(b_rmem), .out_is_load(b_load), .out_alu_pc(b_apc), .out_alu_imm(b_aimm),
        .out_is_branch(b_br), .out_is_jump(b_jmp), .out_illegal(b_ill), .bubble_count(b_bub)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    localparam logic [31:0] I_ADDI1 = 32'h0050_0093;
    localparam logic [31:0] I_LW2   = 32'h0000_A103;
    localparam logic [31:0] I_ADD3  = 32'h0021_01B3;
    localparam logic [31:0] I_LW0   = 32'h0000_A003;
    localparam logic [31:0] I_ADD30 = 32'h0000_01B3;
    localparam logic [31:0] I_SRAI  = 32'h4032_5213;
    localparam logic [31:0] I_BEQ   = 32'hFE20_8EE3;
    localparam logic [31:0] I_SW    = 32'h0020_A423;
    localparam logic [31:0] I_ADDI5 = 32'h0070_0293;
    localparam logic [31:0] I_ADDI6 = 32'h0090_0313;
    localparam logic [31:0] I_ADDI7 = 32'h00B0_0393;
    localparam logic [31:0] I_ADDI8 = 32'h0010_0413;
    localparam logic [31:0] I_ADDI9 = 32'h0010_0493;
    localparam logic [31:0] I_MUL   = 32'h0220_8033;
    localparam logic [31:0] I_BSLLI = 32'h4010_1093;
    localparam logic [31:0] I_BAD   = 32'h0000_007F;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        #2;
        check("rst_valid", a_out_valid, 0);
        check("rst_bub_a", a_bub, 0);
        check("rst_bub_b", b_bub, 0);
        check("rst_rd", a_rd, 0);
        check("rst_imm", a_imm, 0);
        check("rst_in_ready", a_in_ready, 1);
        flush = 1'b1; #1;
        check("rst_in_ready_flush", a_in_ready, 0);
        flush = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // ADDI x1,x0,5
        offer(I_ADDI1, 32'h100); step();
        check("addi_valid", a_out_valid, 1);
        check("addi_rd", a_rd, 1);
        check("addi_rs1", a_rs1, 0);
        check("addi_imm", a_imm, 5);
        check("addi_alu", a_alu, 0);
        check("addi_wreg", a_wreg, 1);
        check("addi_aimm", a_aimm, 1);
        check("addi_pc", a_pc, 32'h100);

        // load-use: LW x2 then ADD x3,x2,x2
        offer(I_LW2, 32'h104); step();
        check("lw_valid", a_out_valid, 1);
        check("lw_load", a_load, 1);
        check("lw_rd", a_rd, 2);
        check("lw_rmem", a_rmem, 1);
        offer(I_ADD3, 32'h108); #1;
        check("hz_in_ready", a_in_ready, 0);
        step();
        check("bubble_valid", a_out_valid, 0);
        check("bubble_cnt", a_bub, 1);
        check("bubble_in_ready", a_in_ready, 1);
        step();
        check("add_valid", a_out_valid, 1);
        check("add_rd", a_rd, 3);
        check("add_pc", a_pc, 32'h108);

        // rd=x0 load never stalls
        offer(I_LW0, 32'h10C); step();
        check("lw0_rd", a_rd, 0);
        offer(I_ADD30, 32'h110); #1;
        check("x0_in_ready", a_in_ready, 1);
        step();
        check("x0_valid", a_out_valid, 1);
        check("x0_pc", a_pc, 32'h110);
        check("x0_bub", a_bub, 1);

        offer(I_SRAI, 32'h114); step();
        check("srai_alu", a_alu, 5'b01101);
        check("srai_imm", a_imm, 3);
        check("srai_rs1", a_rs1, 4);
        check("srai_ill", a_ill, 0);
        offer(I_BEQ, 32'h118); step();
        check("beq_imm", a_imm, 32'hFFFF_FFFC);
        check("beq_alu", a_alu, 5'b01000);
        check("beq_br", a_br, 1);
        check("beq_wreg", a_wreg, 0);
        check("beq_rs2", a_rs2, 2);
        offer(I_SW, 32'h11C); step();
        check("sw_imm", a_imm, 8);
        check("sw_wmem", a_wmem, 1);
        check("sw_wreg", a_wreg, 0);

        // backpressure
        offer(I_ADDI5, 32'h200); step();
        out_ready = 1'b0;
        offer(I_ADDI6, 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", a_in_ready, 0);
            check("bp_valid", a_out_valid, 1);
            check("bp_rd", a_rd, 5);
            check("bp_imm", a_imm, 7);
            check("bp_pc", a_pc, 32'h200);
            step();
        end
        out_ready = 1'b1; #1;
        check("bp_release_ready", a_in_ready, 1);
        step();
        check("bp_b_rd", a_rd, 6);
        check("bp_b_pc", a_pc, 32'h204);
        offer(I_ADDI7, 32'h208); step();
        check("bp_c_rd", a_rd, 7);
        check("bp_c_pc", a_pc, 32'h208);
        in_valid = 1'b0; step();
        check("bp_drain", a_out_valid, 0);

        // flush with a held and an offered instruction
        offer(I_ADDI8, 32'h300); step();
        check("fl_pre_rd", a_rd, 8);
        out_ready = 1'b0;
        offer(I_ADDI9, 32'h304);
        flush = 1'b1; #1;
        check("fl_in_ready", a_in_ready, 0);
        step();
        check("fl_valid", a_out_valid, 0);
        check("fl_rd_zero", a_rd, 0);
        check("fl_bub", a_bub, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("fl_not_captured", a_out_valid, 0);
        check("fl_pc_zero", a_pc, 0);

        // M extension
        offer(I_MUL, 32'h400); step();
        check("mul_ill_a", a_ill, 1);
        check("mul_wreg_a", a_wreg, 0);
        check("mul_valid_a", a_out_valid, 1);
        check("mul_ill_b", b_ill, 0);
        check("mul_alu_b", b_alu, 5'b10000);
        check("mul_wreg_b", b_wreg, 1);
        offer(I_BSLLI, 32'h404); step();
        check("bslli_ill", a_ill, 1);
        check("bslli_wreg", a_wreg, 0);
        offer(I_BAD, 32'h408); step();
        check("badop_ill", b_ill, 1);
        check("badop_wreg", b_wreg, 0);

        // five more bubbles: CNT_W=2 saturates, CNT_W=16 keeps counting
        for (int k = 1; k <= 5; k++) begin
            offer(I_LW2, 32'h500); step();
            offer(I_ADD3, 32'h504); step();
            check("sat_valid", a_out_valid, 0);
            check("sat_bub_a", a_bub, (1 + k > 3) ? 3 : 1 + k);
            check("sat_bub_b", b_bub, 1 + k);
            step();
            check("sat_add_rd", a_rd, 3);
        end

        // asynchronous reset mid-stream
        offer(I_LW2, 32'h600); step();
        check("ar_pre_valid", a_out_valid, 1);
        #3;
        rst_n = 1'b0; #1;
        check("ar_valid_a", a_out_valid, 0);
        check("ar_valid_b", b_out_valid, 0);
        check("ar_bub_a", a_bub, 0);
        check("ar_bub_b", b_bub, 0);
        check("ar_in_ready", a_in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
